// File: rtl/axil_regbank_pkg.sv
// Shared definitions for the AXI-Lite register bank:
// register offsets, response codes and byte-strobe helpers.
package axil_regbank_pkg;

  localparam logic [5:0] REG_ID      = 6'h00;
  localparam logic [5:0] REG_SCRATCH = 6'h04;
  localparam logic [5:0] REG_CTRL    = 6'h08;
  localparam logic [5:0] REG_STATUS  = 6'h0C;
  localparam logic [5:0] REG_IRQ_EN  = 6'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] strb_mask(
    input logic [3:0] strb
  );
    return {{8{strb[3]}}, {8{strb[2]}},
            {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// Byte-strobe merge: old word with strobed bytes
// replaced by the new write data.
module axil_wstrb_merge
  import axil_regbank_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [3:0]  i_strb,
  output logic [31:0] o_val
);

  logic [31:0] w_mask;

  assign w_mask = strb_mask(i_strb);
  assign o_val  = (i_old & ~w_mask) | (i_new & w_mask);

endmodule

// File: rtl/axil_regbank.sv
// AXI-Lite slave register bank: ID, scratch, control,
// W1C event status with interrupt enable and level irq.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'h7C1E_0001,
  parameter int          NUM_EVT    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [NUM_EVT-1:0]    evt,
  output logic [31:0]           ctrl,
  output logic                  irq
);

  localparam logic [31:0] EVT_MASK =
    (NUM_EVT >= 32) ? 32'hFFFF_FFFF :
    32'((64'd1 << NUM_EVT) - 64'd1);

  logic        r_aw_held;
  logic [5:0]  r_aw_off;
  logic        r_w_held;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [31:0] r_scratch;
  logic [31:0] r_ctrl;
  logic [31:0] r_status;
  logic [31:0] r_irq_en;
  logic        r_irq;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_commit;
  logic        w_sel_scratch;
  logic        w_sel_ctrl;
  logic        w_sel_status;
  logic        w_sel_irq_en;
  logic [1:0]  w_bresp;
  logic [5:0]  w_ar_off;
  logic [31:0] w_rdata;
  logic [1:0]  w_rresp;
  logic [31:0] w_clr;
  logic [31:0] w_evt32;
  logic [31:0] w_scratch_nxt;
  logic [31:0] w_ctrl_nxt;
  logic [31:0] w_irq_en_nxt;
  logic        w_unused_addr;

  assign w_unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = !r_aw_held;
  assign s_axi_wready  = !r_w_held;
  assign s_axi_arready = !r_rvalid;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign ctrl          = r_ctrl;
  assign irq           = r_irq;

  assign w_aw_hs  = s_axi_awvalid && !r_aw_held;
  assign w_w_hs   = s_axi_wvalid && !r_w_held;
  assign w_ar_hs  = s_axi_arvalid && !r_rvalid;
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;

  assign w_sel_scratch = w_commit && (r_aw_off == REG_SCRATCH);
  assign w_sel_ctrl    = w_commit && (r_aw_off == REG_CTRL);
  assign w_sel_status  = w_commit && (r_aw_off == REG_STATUS);
  assign w_sel_irq_en  = w_commit && (r_aw_off == REG_IRQ_EN);

  assign w_clr = w_sel_status ?
    (r_wdata & strb_mask(r_wstrb)) : 32'h0;

  always_comb begin
    w_evt32 = '0;
    w_evt32[NUM_EVT-1:0] = evt;
  end

  axil_wstrb_merge u_merge_scratch (
    .i_old  (r_scratch),
    .i_new  (r_wdata),
    .i_strb (r_wstrb),
    .o_val  (w_scratch_nxt)
  );

  axil_wstrb_merge u_merge_ctrl (
    .i_old  (r_ctrl),
    .i_new  (r_wdata),
    .i_strb (r_wstrb),
    .o_val  (w_ctrl_nxt)
  );

  axil_wstrb_merge u_merge_irq_en (
    .i_old  (r_irq_en),
    .i_new  (r_wdata),
    .i_strb (r_wstrb),
    .o_val  (w_irq_en_nxt)
  );

  // ID writes are silently dropped but still answer OKAY
  always_comb begin
    w_bresp = RESP_OKAY;
    unique case (r_aw_off)
      REG_ID, REG_SCRATCH, REG_CTRL,
      REG_STATUS, REG_IRQ_EN: w_bresp = RESP_OKAY;
      default:                w_bresp = RESP_SLVERR;
    endcase
  end

  assign w_ar_off = {s_axi_araddr[5:2], 2'b00};

  always_comb begin
    w_rdata = '0;
    w_rresp = RESP_OKAY;
    unique case (w_ar_off)
      REG_ID:      w_rdata = ID_VALUE;
      REG_SCRATCH: w_rdata = r_scratch;
      REG_CTRL:    w_rdata = r_ctrl;
      REG_STATUS:  w_rdata = r_status;
      REG_IRQ_EN:  w_rdata = r_irq_en;
      default:     w_rresp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_aw_off  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_off  <= {s_axi_awaddr[5:2], 2'b00};
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_bresp;
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
        r_bresp  <= RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= w_rresp;
      end else if (r_rvalid && s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Event set beats a same-cycle W1C clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scratch <= '0;
      r_ctrl    <= '0;
      r_status  <= '0;
      r_irq_en  <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_sel_scratch) r_scratch <= w_scratch_nxt;
      if (w_sel_ctrl)    r_ctrl    <= w_ctrl_nxt;
      if (w_sel_irq_en)  r_irq_en  <= w_irq_en_nxt & EVT_MASK;
      r_status <= (r_status & ~w_clr) | w_evt32;
      r_irq    <= |(r_status & r_irq_en);
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Self-checking bench for axil_regbank: directed scenarios
// plus randomized traffic against a behavioural register model.
module tb_axil_regbank;
  import axil_regbank_pkg::*;

  localparam logic [31:0] ID_VAL = 32'h7C1E_0001;
  localparam int NEVT = 8;
  localparam int TMO  = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [NEVT-1:0] evt = '0;
  logic [31:0] ctrl;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_scratch = '0;
  logic [31:0] m_ctrl = '0;
  logic [31:0] m_status = '0;
  logic [31:0] m_irq_en = '0;

  always #5 clk = ~clk;

  axil_regbank #(
    .ADDR_WIDTH (32),
    .ID_VALUE   (ID_VAL),
    .NUM_EVT    (NEVT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .evt           (evt),
    .ctrl          (ctrl),
    .irq           (irq)
  );

  function automatic logic [31:0] put_bytes(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic model_write(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic [1:0]  resp
  );
    int word;
    word = int'(a[5:0]) / 4;
    resp = 2'b00;
    case (word)
      0: ;
      1: m_scratch = put_bytes(m_scratch, d, s);
      2: m_ctrl = put_bytes(m_ctrl, d, s);
      3: m_status = m_status & ~put_bytes(32'h0, d, s);
      4: m_irq_en = put_bytes(m_irq_en, d, s) & 32'hFF;
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_read(
    input  logic [31:0] a,
    output logic [31:0] d,
    output logic [1:0]  resp
  );
    int word;
    word = int'(a[5:0]) / 4;
    resp = 2'b00;
    d = 32'h0;
    case (word)
      0: d = ID_VAL;
      1: d = m_scratch;
      2: d = m_ctrl;
      3: d = m_status;
      4: d = m_irq_en;
      default: resp = 2'b10;
    endcase
  endtask

  function automatic logic model_irq();
    return |(m_status & m_irq_en);
  endfunction

  task automatic model_reset();
    m_scratch = '0;
    m_ctrl = '0;
    m_status = '0;
    m_irq_en = '0;
  endtask

  task automatic axi_write(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic [1:0]  resp
  );
    int n;
    logic aw_go, w_go;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < TMO) begin
      aw_go = awvalid && awready;
      w_go = wvalid && wready;
      @(negedge clk);
      if (aw_go) awvalid = 1'b0;
      if (w_go) wvalid = 1'b0;
      n++;
    end
    while (!bvalid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_timeout addr=%h bvalid=%b want 1",
               a, bvalid);
    end
    resp = bresp;
  endtask

  task automatic axi_read(
    input  logic [31:0] a,
    output logic [31:0] d,
    output logic [1:0]  resp
  );
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_latency addr=%h rvalid=%b want 1",
               a, rvalid);
    end
    d = rdata;
    resp = rresp;
  endtask

  task automatic pulse_evt(input logic [NEVT-1:0] v);
    @(negedge clk);
    evt = v;
    @(negedge clk);
    evt = '0;
    m_status = m_status | 32'(v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, irq}
        !== 6'b111000) begin
      errors++;
      $display("FAIL reset_flags got=%b want 111000",
               {awready, wready, arready, bvalid, rvalid, irq});
    end
    checks++;
    if (ctrl !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl got=%h want 0", ctrl);
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      errors++;
      $display("FAIL reset_resp got=%h want 0",
               {bresp, rresp, rdata});
    end
  endtask

  task automatic test_id_read();
    logic [31:0] d;
    logic [1:0] r;
    axi_read(32'h0000_0000, d, r);
    checks++;
    if (d !== ID_VAL || r !== 2'b00) begin
      errors++;
      $display("FAIL id_read got=%h/%b want %h/00", d, r, ID_VAL);
    end
    axi_read(32'hABCD_EF40, d, r);
    checks++;
    if (d !== ID_VAL || r !== 2'b00) begin
      errors++;
      $display("FAIL id_upper got=%h/%b want %h/00", d, r, ID_VAL);
    end
  endtask

  task automatic test_scratch_strb();
    logic [31:0] d;
    logic [1:0] r, er;
    axi_write(32'h04, 32'hDEADBEEF, 4'b0101, r);
    model_write(32'h04, 32'hDEADBEEF, 4'b0101, er);
    checks++;
    if (r !== 2'b00) begin
      errors++;
      $display("FAIL scratch_bresp got=%b want 00", r);
    end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h00AD00EF || d !== m_scratch) begin
      errors++;
      $display("FAIL scratch_strb got=%h want 00ad00ef", d);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0] r, er;
    int nb, first;
    axi_write(32'h04, 32'h0, 4'hF, r);
    model_write(32'h04, 32'h0, 4'hF, er);
    @(negedge clk);
    wdata = 32'hDEADBEEF; wstrb = 4'b0101;
    wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wready !== 1'b0 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL w_only got wready=%b bvalid=%b want 0 0",
               wready, bvalid);
    end
    awaddr = 32'h04; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    nb = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      if (bvalid) begin
        nb++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    model_write(32'h04, 32'hDEADBEEF, 4'b0101, er);
    checks++;
    if (nb != 1 || first != 1) begin
      errors++;
      $display("FAIL w_first_bvalid got n=%0d at=%0d want 1 at 1",
               nb, first);
    end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h00AD00EF || d !== m_scratch) begin
      errors++;
      $display("FAIL w_first_data got=%h want 00ad00ef", d);
    end
  endtask

  task automatic test_status_irq();
    logic [31:0] d;
    logic [1:0] r, er;
    pulse_evt(8'h24);
    axi_write(32'h10, 32'h04, 4'hF, r);
    model_write(32'h10, 32'h04, 4'hF, er);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1 || irq !== model_irq()) begin
      errors++;
      $display("FAIL irq_set got=%b want 1", irq);
    end
    axi_write(32'h0C, 32'h04, 4'hF, r);
    model_write(32'h0C, 32'h04, 4'hF, er);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr got=%b want 0", irq);
    end
    axi_read(32'h0C, d, r);
    checks++;
    if (d !== 32'h20 || d !== m_status) begin
      errors++;
      $display("FAIL status_w1c got=%h want 20", d);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    logic [1:0] r;
    pulse_evt(8'h01);
    @(negedge clk);
    awaddr = 32'h0C; awvalid = 1'b1;
    wdata = 32'h01; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    evt = 8'h01;
    @(negedge clk);
    evt = '0;
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL setwin_bvalid got=%b want 1", bvalid);
    end
    m_status = (m_status & ~32'h1) | 32'h1;
    axi_read(32'h0C, d, r);
    checks++;
    if (d[0] !== 1'b1 || d !== m_status) begin
      errors++;
      $display("FAIL set_wins got=%h want %h", d, m_status);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] old_ctrl;
    logic [1:0] er;
    int n;
    old_ctrl = m_ctrl;
    @(negedge clk);
    bready = 1'b0;
    awaddr = 32'h04; wdata = 32'h11223344; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    model_write(32'h04, 32'h11223344, 4'hF, er);
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first got=%b want 1", bvalid);
    end
    awaddr = 32'h08; wdata = 32'hA5A50F0F; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bvalid, awready, wready} !== 3'b100 ||
          ctrl !== old_ctrl) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got=%b ctrl=%h want 100 %h",
                 i, {bvalid, awready, wready}, ctrl, old_ctrl);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got=%b want 0", bvalid);
    end
    n = 0;
    while (!bvalid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    model_write(32'h08, 32'hA5A50F0F, 4'hF, er);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 ||
        ctrl !== 32'hA5A50F0F || ctrl !== m_ctrl) begin
      errors++;
      $display("FAIL bp_second got=%b/%b ctrl=%h want 1/00 a5a50f0f",
               bvalid, bresp, ctrl);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] d;
    logic [1:0] r, er;
    axi_read(32'h20, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++;
      $display("FAIL rd_unmapped got=%h/%b want 0/10", d, r);
    end
    axi_write(32'h3C, 32'hFFFFFFFF, 4'hF, r);
    model_write(32'h3C, 32'hFFFFFFFF, 4'hF, er);
    checks++;
    if (r !== 2'b10 || r !== er) begin
      errors++;
      $display("FAIL wr_unmapped got=%b want 10", r);
    end
    axi_write(32'h00, 32'h12345678, 4'hF, r);
    model_write(32'h00, 32'h12345678, 4'hF, er);
    axi_read(32'h00, d, er);
    checks++;
    if (r !== 2'b00 || d !== ID_VAL) begin
      errors++;
      $display("FAIL wr_id got=%b/%h want 00/%h", r, d, ID_VAL);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, ed;
    logic [1:0] r, er;
    logic [3:0] s;
    int op;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      a = ($urandom() & 32'hFFFF_FFC3) |
          (32'($urandom_range(0, 15)) << 2);
      d = $urandom();
      s = 4'($urandom_range(0, 15));
      if (op == 0) begin
        pulse_evt(NEVT'($urandom()));
      end else if (op == 1) begin
        axi_write(a, d, s, r);
        model_write(a, d, s, er);
        checks++;
        if (r !== er) begin
          errors++;
          $display("FAIL rnd_bresp i=%0d addr=%h got=%b want %b",
                   i, a, r, er);
        end
      end else begin
        axi_read(a, d, r);
        model_read(a, ed, er);
        checks++;
        if (d !== ed || r !== er) begin
          errors++;
          $display("FAIL rnd_read i=%0d addr=%h got=%h/%b want %h/%b",
                   i, a, d, r, ed, er);
        end
      end
      repeat (2) @(negedge clk);
      checks++;
      if (irq !== model_irq() || ctrl !== m_ctrl) begin
        errors++;
        $display("FAIL rnd_irq i=%0d got=%b/%h want %b/%h",
                 i, irq, ctrl, model_irq(), m_ctrl);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    logic [1:0] r;
    int nb;
    pulse_evt(8'hFF);
    @(negedge clk);
    bready = 1'b0;
    awaddr = 32'h08; wdata = 32'h12345678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_bvalid got=%b want 1", bvalid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bvalid !== 1'b0 || ctrl !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got=%b ctrl=%h irq=%b want 0 0 0",
               bvalid, ctrl, irq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bready = 1'b1;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      if (bvalid) nb++;
      @(negedge clk);
    end
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL rst_no_resp got=%0d want 0", nb);
    end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h0 || d !== m_ctrl) begin
      errors++;
      $display("FAIL rst_ctrl got=%h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_scratch_strb();
    test_w_before_aw();
    test_status_irq();
    test_set_wins();
    test_backpressure();
    test_slverr();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
